// File: rtl/input_spi_rx.sv
// Nibble-wide SPI receiver: synchronizes spi_clk/spi_en/spi_data into clk, pairs nibbles
// (high first) into bytes and buffers them in a show-ahead FIFO. Optional: INPUT_SPI_ERRCNT_EN.
`timescale 1ns/1ps
module input_spi_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_en,
  input  logic [3:0] spi_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow,
  output logic       frame_err,
  input  logic       err_clr
`ifdef INPUT_SPI_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {S_IDLE, S_HALF} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_en_sync;
  logic [3:0]             r_data_sync [SYNC_STAGES];
  logic                   r_clk_prev;

  state_t      r_state;
  logic [3:0]  r_hi;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  logic        r_frame_err;

  logic       w_sclk;
  logic       w_sen;
  logic [3:0] w_sdata;
  logic       w_nib_ev;
  logic       w_wr;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_ovf_ev;
  logic       w_ferr_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '0;
      r_en_sync  <= '0;
      r_clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= 4'h0;
    end else begin
      r_clk_sync     <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
      r_en_sync      <= {r_en_sync[SYNC_STAGES-2:0], spi_en};
      r_data_sync[0] <= spi_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
      r_clk_prev     <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk   = r_clk_sync[SYNC_STAGES-1];
  assign w_sen    = r_en_sync[SYNC_STAGES-1];
  assign w_sdata  = r_data_sync[SYNC_STAGES-1];
  assign w_nib_ev = w_sclk & ~r_clk_prev & w_sen;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = ~w_empty & out_ready;
  assign w_wr      = w_nib_ev & (r_state == S_HALF);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign w_push    = w_wr & (~w_full | w_pop);
  assign w_ovf_ev  = w_wr & w_full & ~w_pop;
  assign w_ferr_ev = (r_state == S_HALF) & ~w_sen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hi    <= 4'h0;
    end else if (r_state == S_IDLE) begin
      if (w_nib_ev) begin
        r_hi    <= w_sdata;
        r_state <= S_HALF;
      end
    end else begin
      if (w_nib_ev || !w_sen) r_state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= {r_hi, w_sdata};
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Error events take priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_ev)     r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_ferr_ev)    r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
    end
  end

`ifdef INPUT_SPI_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= 8'h00;
    else if ((w_ovf_ev || w_ferr_ev) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign err_cnt = r_err_cnt;
`endif

  assign out_data  = r_mem[r_rptr[AW-1:0]];
  assign out_valid = ~w_empty;
  assign busy      = (r_state == S_HALF);
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_input_spi_rx.sv
// Bench for input_spi_rx: random SPI framing against a queue-based reference model,
// plus directed reset, burst/overflow, frame-error and flag-priority scenarios.
`timescale 1ns/1ps
module tb_input_spi_rx;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_en = 1'b0;
  logic [3:0] spi_data = 4'h0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  wire  [7:0] out_data;
  wire        out_valid;
  wire        busy;
  wire        overflow;
  wire        frame_err;
`ifdef INPUT_SPI_ERRCNT_EN
  wire  [7:0] err_cnt;
`endif

  input_spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
`ifdef INPUT_SPI_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // clock/reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit rand_ready = 0;
  bit rand_clr = 0;
  int vcnt = 0;
  logic [7:0] vlast = 8'h00;
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue, inputs seen SYNC edges late
  logic [7:0] exp_q[$];
  logic [5:0] in_log[$];
  bit         m_half;
  logic [3:0] m_hi;
  bit         m_ovf;
  bit         m_ferr;
  int         m_cnt;

  task automatic model_reset();
    exp_q.delete();
    in_log.delete();
    for (int i = 0; i < SYNC + 1; i++) in_log.push_back(6'h00);
    m_half = 0; m_hi = 4'h0; m_ovf = 0; m_ferr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [5:0] cur;
    logic [5:0] prv;
    bit ev, pop, ovf_ev, ferr_ev;
    in_log.push_back({spi_clk, spi_en, spi_data});
    while (in_log.size() > SYNC + 2) void'(in_log.pop_front());
    cur = in_log[in_log.size() - 1 - SYNC];
    prv = in_log[in_log.size() - 2 - SYNC];
    ev = cur[5] && !prv[5] && cur[4];
    pop = (exp_q.size() > 0) && out_ready;
    ovf_ev = 0;
    ferr_ev = 0;
    if (pop) void'(exp_q.pop_front());
    if (ev && !m_half) begin
      m_hi = cur[3:0];
      m_half = 1;
    end else if (ev) begin
      m_half = 0;
      if (exp_q.size() < DEPTH) exp_q.push_back({m_hi, cur[3:0]});
      else ovf_ev = 1;
    end else if (m_half && !cur[4]) begin
      m_half = 0;
      ferr_ev = 1;
    end
    if (ovf_ev) m_ovf = 1; else if (err_clr) m_ovf = 0;
    if (ferr_ev) m_ferr = 1; else if (err_clr) m_ferr = 0;
    if ((ovf_ev || ferr_ev) && m_cnt < 255) m_cnt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // scoreboard compare, every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
      check("busy", busy, m_half);
      check("overflow", overflow, m_ovf);
      check("frame_err", frame_err, m_ferr);
`ifdef INPUT_SPI_ERRCNT_EN
      check("err_cnt", err_cnt, m_cnt);
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      vcnt++;
      vlast = out_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    if (rand_clr) err_clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // pulse: 0 none, 1 err_clr, 2 out_ready -- asserted for exactly the edge that consumes this nibble
  task automatic send_nib(input logic [3:0] n, input int pulse, input int ph);
    int lo, hi;
    lo = (ph != 0) ? ph : $urandom_range(SYNC + 1, SYNC + 4);
    hi = (ph != 0) ? ph : $urandom_range(SYNC + 1, SYNC + 4);
    spi_en = 1'b1;
    spi_data = n;
    ticks(lo);
    spi_clk = 1'b1;
    if (pulse != 0) begin
      ticks(SYNC);
      if (pulse == 1) err_clr = 1'b1; else out_ready = 1'b1;
      tick();
      err_clr = 1'b0;
      if (pulse == 2) out_ready = 1'b0;
      ticks(hi - SYNC - 1);
    end else begin
      ticks(hi);
    end
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int pulse, input int ph);
    send_nib(b[7:4], 0, ph);
    send_nib(b[3:0], pulse, ph);
  endtask

  task automatic end_frame();
    spi_en = 1'b0;
    ticks(SYNC + 3);
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic drain();
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid) break;
      got_q.push_back(out_data);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] b;
    int nb;

    // reset state
    ticks(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    ticks(2);

    // single byte
    out_ready = 1'b1;
    vcnt = 0;
    send_byte(8'hA5, 0, 0);
    end_frame();
    ticks(3);
    check("single_data", vlast, 8'hA5);
    check("single_vcycles", vcnt, 1);

    // burst into a 4-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'(i), 0, 0);
    end_frame();
    check("burst_ovf", overflow, 1'b1);
    check("burst_model_size", exp_q.size(), 4);
    drain();
    check("burst_cnt", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("burst_order", got_q[i], 8'(i));
    clear_flags();

    // frame error on a dangling high nibble
    send_nib(4'h7, 0, 0);
    end_frame();
    check("ferr_set", frame_err, 1'b1);
    check("ferr_no_valid", out_valid, 1'b0);
    check("ferr_busy", busy, 1'b0);
    clear_flags();
    check("ferr_clr", frame_err, 1'b0);
    out_ready = 1'b1;
    vcnt = 0;
    send_byte(8'h3C, 0, 0);
    end_frame();
    ticks(3);
    check("after_ferr_data", vlast, 8'h3C);
    check("after_ferr_vcycles", vcnt, 1);

    // flag priority and full FIFO pop+write
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 0, 0);
    send_byte(8'h14, 1, 0);
    tick();
    check("prio_ovf_kept", overflow, 1'b1);
    clear_flags();
    check("prio_ovf_clr", overflow, 1'b0);
    send_byte(8'h15, 2, 0);
    end_frame();
    check("popwr_no_ovf", overflow, 1'b0);
    check("popwr_model_size", exp_q.size(), 4);
    drain();
    check("popwr_cnt", got_q.size(), 4);
    check("popwr_0", got_q[0], 8'h11);
    check("popwr_1", got_q[1], 8'h12);
    check("popwr_2", got_q[2], 8'h13);
    check("popwr_3", got_q[3], 8'h15);

    // randomized frames, partial bytes, random ready and clear
    rand_ready = 1;
    rand_clr = 1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b, 0, 0);
      end
      if ($urandom_range(0, 4) == 0) send_nib(4'($urandom_range(0, 15)), 0, 0);
      end_frame();
    end
    rand_ready = 0;
    rand_clr = 0;
    err_clr = 1'b0;
    out_ready = 1'b1;
    ticks(8);
    clear_flags();

    // reset mid-byte with bytes buffered
    out_ready = 1'b0;
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    send_nib(4'h4, 0, 0);
    tick();
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_model_size", exp_q.size(), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    spi_en = 1'b0;
    spi_clk = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    out_ready = 1'b1;
    vcnt = 0;
    send_byte(8'h5A, 0, 0);
    end_frame();
    ticks(3);
    check("post_rst_data", vlast, 8'h5A);
    check("post_rst_vcycles", vcnt, 1);

`ifdef INPUT_SPI_ERRCNT_EN
    // saturating error counter
    out_ready = 1'b0;
    for (int i = 0; i < 304; i++) send_byte(8'(i), 0, SYNC + 1);
    end_frame();
    check("errcnt_sat", err_cnt, 8'hFF);
    clear_flags();
    check("errcnt_kept", err_cnt, 8'hFF);
    drain();
`endif

    ticks(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
